// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: onehot bit positions, response FSM
// encoding and the default reset PC.
package mem_wb_pkg;

  // sel_wbdata bit positions
  localparam int SEL_ALU   = 0;
  localparam int SEL_LOAD  = 1;
  localparam int SEL_LINK  = 2;
  localparam int SEL_MERGE = 3;

  // lubhw_con bit positions
  localparam int LD_LW  = 0;
  localparam int LD_LB  = 1;
  localparam int LD_LBU = 2;
  localparam int LD_LH  = 3;
  localparam int LD_LHU = 4;

  // onehot: LWL at offset k is bit k, LWR at offset k is bit 4+k
  localparam int LWL_BASE = 0;
  localparam int LWR_BASE = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CANCEL = 2'd3
  } state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: sign/zero extension for LB/LBU/LH/LHU/LW and
// the LWL/LWR merge of the read word with the old rt value.
module mem_wb_stage_load_align
  import mem_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] rt,
  input  logic [1:0]  off,
  input  logic [4:0]  lubhw_con,
  input  logic [7:0]  onehot,
  output logic [31:0] ext_word,
  output logic [31:0] merge_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = word >> {off, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    if (lubhw_con[LD_LB]) begin
      ext_word = {{24{byte_sel[7]}}, byte_sel};
    end else if (lubhw_con[LD_LBU]) begin
      ext_word = {24'h0, byte_sel};
    end else if (lubhw_con[LD_LH]) begin
      ext_word = {{16{half_sel[15]}}, half_sel};
    end else if (lubhw_con[LD_LHU]) begin
      ext_word = {16'h0, half_sel};
    end else if (lubhw_con[LD_LW]) begin
      ext_word = word;
    end else begin
      ext_word = 32'h0;
    end
  end

  always_comb begin
    case (onehot)
      8'b0000_0001: merge_word = {word[7:0],  rt[23:0]};
      8'b0000_0010: merge_word = {word[15:0], rt[15:0]};
      8'b0000_0100: merge_word = {word[23:0], rt[7:0]};
      8'b0000_1000: merge_word = word;
      8'b0001_0000: merge_word = word;
      8'b0010_0000: merge_word = {rt[31:24], word[31:8]};
      8'b0100_0000: merge_word = {rt[31:16], word[31:16]};
      8'b1000_0000: merge_word = {rt[31:8],  word[31:24]};
      default:      merge_word = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: holds the EXE result, waits for load data, aligns it and drives
// the register-file write port. Build option DM_HANDSHAKE_EN enables the
// variable-latency dm_data_ok handshake with its response FSM and read buffer.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  output logic        allowin_mem,
  input  logic        flush,
  input  logic [31:0] aluout_exe,
  input  logic [3:0]  sel_wbdata_exe,
  input  logic [4:0]  lubhw_con_exe,
  input  logic [7:0]  onehot_exe,
  input  logic [31:0] PC_exe,
  input  logic [31:0] NNPC_exe,
  input  logic [4:0]  regnum_exe,
  input  logic [31:0] rt_data_exe,
  input  logic [31:0] dm_rdata,
  input  logic        dm_data_ok,
  input  logic        allowin_wb,
  output logic        wb_valid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc
);

  logic        mem_valid;
  logic [31:0] aluout, pc, nnpc, rt_data;
  logic [3:0]  sel_wbdata;
  logic [4:0]  lubhw_con, regnum;
  logic [7:0]  onehot;

  logic        is_load, ready_go, accept, retire, buf_valid;
  logic [31:0] read_word, ext_word, merge_word, wb_data;
  state_t      state;

  assign is_load = (|lubhw_con) | (|onehot);

`ifdef DM_HANDSHAKE_EN
  state_t      state_next;
  logic [31:0] rdata_buf;
  logic        buf_load, buf_clear;

  assign read_word = buf_valid ? rdata_buf : dm_rdata;
  assign ready_go  = !is_load || dm_data_ok || buf_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // A data_ok coinciding with a flush in WAIT is the cancelled response itself,
  // so there is nothing left to discard.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mem_valid && is_load && !flush && !dm_data_ok) state_next = ST_WAIT;
        else if (mem_valid && is_load && !flush && !allowin_wb) state_next = ST_HOLD;
        else state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (flush) state_next = dm_data_ok ? ST_IDLE : ST_CANCEL;
        else if (dm_data_ok) state_next = allowin_wb ? ST_IDLE : ST_HOLD;
        else state_next = ST_WAIT;
      end
      ST_HOLD:   state_next = (flush || allowin_wb) ? ST_IDLE : ST_HOLD;
      ST_CANCEL: state_next = dm_data_ok ? ST_IDLE : ST_CANCEL;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    buf_load  = (state_next == ST_HOLD) && (state != ST_HOLD);
    buf_clear = (state == ST_HOLD) && (state_next != ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      rdata_buf <= 32'h0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      rdata_buf <= dm_rdata;
    end else if (buf_clear) begin
      buf_valid <= 1'b0;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = dm_data_ok ^ is_load;
  assign state     = ST_IDLE;
  assign buf_valid = 1'b0;
  assign read_word = dm_rdata;
  assign ready_go  = 1'b1;
`endif

  assign allowin_mem = (state != ST_CANCEL) && (!mem_valid || (ready_go && allowin_wb));
  assign accept      = exe_valid && allowin_mem;
  assign retire      = mem_valid && ready_go && allowin_wb && !flush;

  // flush wins over a simultaneous accept or retire
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      aluout     <= 32'h0;
      sel_wbdata <= 4'h0;
      lubhw_con  <= 5'h0;
      onehot     <= 8'h0;
      pc         <= 32'h0;
      nnpc       <= 32'h0;
      regnum     <= 5'h0;
      rt_data    <= 32'h0;
    end else begin
      if (flush)       mem_valid <= 1'b0;
      else if (accept) mem_valid <= 1'b1;
      else if (retire) mem_valid <= 1'b0;
      if (accept) begin
        aluout     <= aluout_exe;
        sel_wbdata <= sel_wbdata_exe;
        lubhw_con  <= lubhw_con_exe;
        onehot     <= onehot_exe;
        pc         <= PC_exe;
        nnpc       <= NNPC_exe;
        regnum     <= regnum_exe;
        rt_data    <= rt_data_exe;
      end
    end
  end

  mem_wb_stage_load_align u_align (
    .word       (read_word),
    .rt         (rt_data),
    .off        (aluout[1:0]),
    .lubhw_con  (lubhw_con),
    .onehot     (onehot),
    .ext_word   (ext_word),
    .merge_word (merge_word)
  );

  assign wb_data = ({32{sel_wbdata[SEL_ALU]}}   & aluout)
                 | ({32{sel_wbdata[SEL_LOAD]}}  & ext_word)
                 | ({32{sel_wbdata[SEL_LINK]}}  & nnpc)
                 | ({32{sel_wbdata[SEL_MERGE]}} & merge_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'h0;
      rf_wdata    <= 32'h0;
      debug_wb_pc <= RESET_PC;
    end else if (retire) begin
      wb_valid    <= 1'b1;
      rf_we       <= (regnum != 5'h0);
      rf_waddr    <= regnum;
      rf_wdata    <= wb_data;
      debug_wb_pc <= pc;
    end else begin
      wb_valid    <= 1'b0;
      rf_we       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage plus hand-written multi-cycle
// sequences (stall/hold, back-to-back, flush, flush during a load wait).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, exe_valid, flush, dm_data_ok, allowin_wb;
  logic        allowin_mem, wb_valid, rf_we;
  logic [31:0] aluout_exe, PC_exe, NNPC_exe, rt_data_exe, dm_rdata, rf_wdata, debug_wb_pc;
  logic [3:0]  sel_wbdata_exe;
  logic [4:0]  lubhw_con_exe, regnum_exe, rf_waddr;
  logic [7:0]  onehot_exe;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .allowin_mem(allowin_mem), .flush(flush),
    .aluout_exe(aluout_exe), .sel_wbdata_exe(sel_wbdata_exe), .lubhw_con_exe(lubhw_con_exe),
    .onehot_exe(onehot_exe), .PC_exe(PC_exe), .NNPC_exe(NNPC_exe), .regnum_exe(regnum_exe),
    .rt_data_exe(rt_data_exe), .dm_rdata(dm_rdata), .dm_data_ok(dm_data_ok),
    .allowin_wb(allowin_wb), .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  lub;
    logic [7:0]  oh;
    logic [31:0] alu;
    logic [31:0] nnpc;
    logic [4:0]  rn;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_exe(input logic [3:0] sel, input logic [4:0] lub, input logic [7:0] oh,
                           input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] nnpc,
                           input logic [4:0] rn, input logic [31:0] rt);
    exe_valid      = 1'b1;
    sel_wbdata_exe = sel;
    lubhw_con_exe  = lub;
    onehot_exe     = oh;
    aluout_exe     = alu;
    PC_exe         = pc;
    NNPC_exe       = nnpc;
    regnum_exe     = rn;
    rt_data_exe    = rt;
  endtask

  initial begin
    logic [31:0] pc_v;
    //            sel      lub       oh            alu           nnpc          rn     rt            rdata         expected      we
    vecs[0]  = '{4'b0001, 5'b00000, 8'b0000_0000, 32'h0000_1234, 32'h0000_0008, 5'd5,  32'h0,         32'h0,         32'h0000_1234, 1'b1};
    vecs[1]  = '{4'b0010, 5'b00010, 8'b0000_0000, 32'h0000_0102, 32'h0,         5'd6,  32'h0,         32'h1280_3456, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{4'b0010, 5'b00100, 8'b0000_0000, 32'h0000_0102, 32'h0,         5'd6,  32'h0,         32'h1280_3456, 32'h0000_0080, 1'b1};
    vecs[3]  = '{4'b0010, 5'b01000, 8'b0000_0000, 32'h0000_0102, 32'h0,         5'd8,  32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 1'b1};
    vecs[4]  = '{4'b0010, 5'b10000, 8'b0000_0000, 32'h0000_0100, 32'h0,         5'd9,  32'h0,         32'h8001_ABCD, 32'h0000_ABCD, 1'b1};
    vecs[5]  = '{4'b0010, 5'b00001, 8'b0000_0000, 32'h0000_0104, 32'h0,         5'd10, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{4'b1000, 5'b00000, 8'b0000_0010, 32'h0000_2001, 32'h0,         5'd11, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 1'b1};
    vecs[7]  = '{4'b1000, 5'b00000, 8'b0100_0000, 32'h0000_2002, 32'h0,         5'd12, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 1'b1};
    vecs[8]  = '{4'b0010, 5'b00010, 8'b0000_0000, 32'h0000_3003, 32'h0,         5'd13, 32'h0,         32'h7F00_0000, 32'h0000_007F, 1'b1};
    vecs[9]  = '{4'b1000, 5'b00000, 8'b0000_1000, 32'h0000_0003, 32'h0,         5'd14, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1'b1};
    vecs[10] = '{4'b1000, 5'b00000, 8'b0001_0000, 32'h0000_0000, 32'h0,         5'd15, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1'b1};
    vecs[11] = '{4'b1000, 5'b00000, 8'b0000_0001, 32'h0000_0000, 32'h0,         5'd16, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD, 1'b1};
    vecs[12] = '{4'b1000, 5'b00000, 8'b1000_0000, 32'h0000_0003, 32'h0,         5'd17, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11, 1'b1};
    vecs[13] = '{4'b0100, 5'b00000, 8'b0000_0000, 32'h0000_5555, 32'hBFC0_0108, 5'd31, 32'h0,         32'h0,         32'hBFC0_0108, 1'b1};
    vecs[14] = '{4'b0000, 5'b00000, 8'b0000_0000, 32'h0000_9999, 32'h0,         5'd7,  32'h0,         32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{4'b0001, 5'b00000, 8'b0000_0000, 32'hABCD_0000, 32'h0,         5'd0,  32'h0,         32'h0,         32'hABCD_0000, 1'b0};

    rst = 1'b1; exe_valid = 1'b0; flush = 1'b0; dm_data_ok = 1'b0; allowin_wb = 1'b1;
    dm_rdata = 32'h0;
    drive_exe(4'h0, 5'h0, 8'h0, 32'h0, 32'h0, 32'h0, 5'h0, 32'h0);
    exe_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("reset rf_we", {31'h0, rf_we}, 32'h0);
    chk("reset rf_waddr", {27'h0, rf_waddr}, 32'h0);
    chk("reset rf_wdata", rf_wdata, 32'h0);
    chk("reset debug_wb_pc", debug_wb_pc, 32'hbfc0_0000);
    chk("reset allowin_mem", {31'h0, allowin_mem}, 32'h1);

    // table: accept, one MEM cycle with data, check retired outputs
    for (int i = 0; i < 16; i++) begin
      pc_v = 32'hbfc0_1000 + 32'(i) * 32'd4;
      drive_exe(vecs[i].sel, vecs[i].lub, vecs[i].oh, vecs[i].alu, pc_v, vecs[i].nnpc, vecs[i].rn, vecs[i].rt);
      @(negedge clk);
      exe_valid  = 1'b0;
      dm_rdata   = vecs[i].rdata;
      dm_data_ok = (vecs[i].lub != 5'h0) || (vecs[i].oh != 8'h0);
      @(negedge clk);
      dm_data_ok = 1'b0;
      chk($sformatf("vec%0d wb_valid", i), {31'h0, wb_valid}, 32'h1);
      chk($sformatf("vec%0d rf_we", i), {31'h0, rf_we}, {31'h0, vecs[i].exp_we});
      chk($sformatf("vec%0d rf_waddr", i), {27'h0, rf_waddr}, {27'h0, vecs[i].rn});
      chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d debug_wb_pc", i), debug_wb_pc, pc_v);
    end

    // load whose data arrives while the consumer stalls for 3 cycles
    @(negedge clk);
    drive_exe(4'b0010, 5'b00001, 8'h0, 32'h0000_0200, 32'hbfc0_2000, 32'h0, 5'd20, 32'h0);
    @(negedge clk);
    exe_valid = 1'b0; allowin_wb = 1'b0; dm_rdata = 32'hCAFE_F00D; dm_data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dm_data_ok = 1'b0;
`ifdef DM_HANDSHAKE_EN
      dm_rdata = 32'h0BAD_0BAD;
`endif
      chk($sformatf("stall%0d allowin_mem", k), {31'h0, allowin_mem}, 32'h0);
      chk($sformatf("stall%0d wb_valid", k), {31'h0, wb_valid}, 32'h0);
    end
    allowin_wb = 1'b1;
    #1;
    chk("stall release allowin_mem", {31'h0, allowin_mem}, 32'h1);
    @(negedge clk);
    chk("stall retire wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("stall retire rf_wdata", rf_wdata, 32'hCAFE_F00D);
    chk("stall retire rf_waddr", {27'h0, rf_waddr}, 32'd20);

    // back-to-back ALU instructions retire on consecutive cycles
    drive_exe(4'b0001, 5'h0, 8'h0, 32'h0000_00A1, 32'hbfc0_3000, 32'h0, 5'd1, 32'h0);
    @(negedge clk);
    chk("b2b allowin_mem", {31'h0, allowin_mem}, 32'h1);
    drive_exe(4'b0001, 5'h0, 8'h0, 32'h0000_00B2, 32'hbfc0_3004, 32'h0, 5'd2, 32'h0);
    @(negedge clk);
    exe_valid = 1'b0;
    chk("b2b first rf_wdata", rf_wdata, 32'h0000_00A1);
    chk("b2b first wb_valid", {31'h0, wb_valid}, 32'h1);
    @(negedge clk);
    chk("b2b second rf_wdata", rf_wdata, 32'h0000_00B2);
    chk("b2b second debug_wb_pc", debug_wb_pc, 32'hbfc0_3004);

    // flush of a non-load instruction held in MEM
    drive_exe(4'b0001, 5'h0, 8'h0, 32'h0000_0777, 32'hbfc0_4000, 32'h0, 5'd3, 32'h0);
    @(negedge clk);
    exe_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("flush rf_we", {31'h0, rf_we}, 32'h0);
    chk("flush debug_wb_pc held", debug_wb_pc, 32'hbfc0_3004);
    chk("flush allowin_mem", {31'h0, allowin_mem}, 32'h1);

`ifdef DM_HANDSHAKE_EN
    // flush during WAIT: the late response must be dropped
    drive_exe(4'b0010, 5'b00001, 8'h0, 32'h0000_0300, 32'hbfc0_5000, 32'h0, 5'd4, 32'h0);
    @(negedge clk);
    exe_valid = 1'b0;
    chk("wait allowin_mem", {31'h0, allowin_mem}, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("cancel allowin_mem", {31'h0, allowin_mem}, 32'h0);
    chk("cancel wb_valid", {31'h0, wb_valid}, 32'h0);
    dm_rdata = 32'h5555_AAAA; dm_data_ok = 1'b1;
    @(negedge clk);
    dm_data_ok = 1'b0;
    chk("drop wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("drop allowin_mem", {31'h0, allowin_mem}, 32'h1);
`endif

    @(negedge clk);
    chk("idle wb_valid", {31'h0, wb_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
